cond_unit: RTL and testbench
============================

COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 Parameter: CNT_W, default 16, width of the squash counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 ALUFlags  input  4  ALU flags packed {V,N,Z,C} (bit3=V, bit2=N, bit1=Z, bit0=C).
REQ-005 Cond  input  4  instruction condition field.
REQ-006 FlagW  input  2  flag write request: [1] updates N,Z; [0] updates C,V.
REQ-007 valid  input  1  an instruction is present this cycle.
REQ-008 stall  input  1  hold all state, suppress all write-enables.
REQ-009 PCS, RegW, MemW  input  1 each  unqualified write requests from the decoder.
REQ-010 PCSrc, RegWrite, MemWrite  output  1 each  requests qualified by CondEx.
REQ-011 CondEx  output  1  condition evaluated true against the stored flags.
REQ-012 Flags  output  4  stored flags, same {V,N,Z,C} packing.
REQ-013 squash_cnt  output  CNT_W  count of valid instructions whose condition failed.
REQ-014 cnt_clr  input  1  synchronous clear of squash_cnt.

Function
REQ-015 CondEx SHALL be combinational from Cond and the stored Flags, never from ALUFlags of the same cycle.
REQ-016 Decode SHALL be: 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 1 (macro-dependent, REQ-027).
REQ-017 PCSrc/RegWrite/MemWrite SHALL equal PCS/RegW/MemW AND CondEx AND valid AND ~stall, with zero latency.
REQ-018 On a clock edge with valid & CondEx & ~stall: FlagW[1] loads N,Z from ALUFlags; FlagW[0] loads C,V from ALUFlags; unselected flags hold.
REQ-019 Flag updates SHALL become visible to CondEx exactly one cycle after the writing instruction.
REQ-020 A failed-condition instruction SHALL NOT update flags, even with FlagW set.
REQ-021 squash_cnt SHALL increment on each edge with valid & ~CondEx & ~stall, saturate at all-ones, and not wrap.
REQ-022 cnt_clr SHALL have priority over increment; the counter reads 0 the next cycle.
REQ-023 With stall=1, Flags and squash_cnt SHALL hold, and all qualified outputs SHALL be 0.

Reset
REQ-024 reset_n low SHALL immediately force Flags=4'b0000, squash_cnt=0 (and trap=0 if present), independent of clk.
REQ-025 After reset, stored Z=0, so Cond=0000 SHALL evaluate false and Cond=0001 true.
REQ-026 Reset asserted mid-instruction SHALL discard any pending flag write; there is no partial update.

Configuration
REQ-027 Macro COND_NV_TRAP_EN: when defined, Cond=1111 SHALL evaluate false and a registered output trap (1 bit) SHALL pulse high for one cycle after each valid, non-stalled Cond=1111 instruction; when undefined, Cond=1111 behaves as 1110 (always) and no trap port exists.

Structure
REQ-028 A shared package SHALL hold the condition-code enum (EQ..AL, NV), the flag bit-index constants (V=3, N=2, Z=1, C=0), and the FlagW field constants.
REQ-029 Condition decode SHALL be a separate combinational sub-module cond_check (Cond, Flags -> CondEx); the flag register, counter, and qualifiers stay in cond_unit.

Verification
REQ-030 Reset, then Cond=0000, valid=1, RegW=1 -> CondEx=0, RegWrite=0, squash_cnt=1 on the next cycle.
REQ-031 Cycle 1: Cond=1110, FlagW=2'b11, ALUFlags=4'b0010 (Z=1); cycle 2: Cond=0000, RegW=1 -> Flags=0010, RegWrite=1 in cycle 2 only.
REQ-032 Stored flags N=1, V=0; Cond=1011 with MemW=1 -> MemWrite=1; Cond=1010 -> MemWrite=0 and flags unchanged despite FlagW=2'b11.
REQ-033 FlagW=2'b10 with ALUFlags=4'b1111 from Flags=0000 -> Flags=0110 (only N,Z loaded).
REQ-034 Force squash_cnt to all-ones minus 1, then issue 3 failed instructions -> the counter holds at all-ones; cnt_clr together with a failed instruction -> 0.
REQ-035 Stall=1 with a valid AL instruction and FlagW=2'b11 -> all outputs 0 and Flags unchanged; assert reset_n low mid-cycle -> Flags=0 immediately.

Source files
------------

// File: rtl/cond_unit_pkg.sv
// Shared definitions for the conditional-execution unit: condition codes,
// flag bit positions inside the packed {V,N,Z,C} word, and FlagW fields.
package cond_unit_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_C = 0;

    // FlagW bit that loads N,Z and bit that loads C,V
    localparam int unsigned FLAGW_NZ = 1;
    localparam int unsigned FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition decode: Cond against stored {V,N,Z,C} flags.
// Optional macro COND_NV_TRAP_EN makes NV (1111) evaluate false.
import cond_unit_pkg::*;

module cond_check (
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    // Evaluate the condition field against the stored flags
    always_comb begin
        n      = Flags[FLAG_N];
        z      = Flags[FLAG_Z];
        c      = Flags[FLAG_C];
        v      = Flags[FLAG_V];
        CondEx = 1'b0;
        case (cond_e'(Cond))
            EQ: CondEx = z;
            NE: CondEx = ~z;
            CS: CondEx = c;
            CC: CondEx = ~c;
            MI: CondEx = n;
            PL: CondEx = ~n;
            VS: CondEx = v;
            VC: CondEx = ~v;
            HI: CondEx = c & ~z;
            LS: CondEx = ~c | z;
            GE: CondEx = (n == v);
            LT: CondEx = (n != v);
            GT: CondEx = ~z & (n == v);
            LE: CondEx = z | (n != v);
            AL: CondEx = 1'b1;
`ifdef COND_NV_TRAP_EN
            NV: CondEx = 1'b0;
`else
            NV: CondEx = 1'b1;
`endif
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: stored flags, condition qualification of
// write requests, and a saturating count of squashed instructions.
// Optional macro COND_NV_TRAP_EN adds a registered trap pulse for NV.
import cond_unit_pkg::*;

module cond_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       ALUFlags,
    input  logic [3:0]       Cond,
    input  logic [1:0]       FlagW,
    input  logic             valid,
    input  logic             stall,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             cnt_clr,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] squash_cnt
`ifdef COND_NV_TRAP_EN
    ,
    output logic             trap
`endif
);

    logic [3:0]       flags_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fire;

    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (CondEx)
    );

    // Qualify decoder write requests with condition, valid and stall
    always_comb begin
        fire     = valid & ~stall;
        PCSrc    = PCS  & CondEx & fire;
        RegWrite = RegW & CondEx & fire;
        MemWrite = MemW & CondEx & fire;
    end

    // Flag register: selected flag pairs load only for executed instructions
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else if (fire && CondEx) begin
            if (FlagW[FLAGW_NZ]) begin
                flags_q[FLAG_N] <= ALUFlags[FLAG_N];
                flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[FLAGW_CV]) begin
                flags_q[FLAG_C] <= ALUFlags[FLAG_C];
                flags_q[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    // Squash counter: stall holds it, clear beats increment, saturates at all-ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (!stall) begin
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (valid && !CondEx && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef COND_NV_TRAP_EN
    // One-cycle trap pulse after each issued NV instruction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trap <= 1'b0;
        end else begin
            trap <= fire && (cond_e'(Cond) == NV);
        end
    end
`endif

    assign Flags      = flags_q;
    assign squash_cnt = cnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: decode table, hand sequences for the
// multi-cycle corners, and randomized traffic against a behavioural model.
module tb_cond_unit;

    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [3:0]    ALUFlags, Cond;
    logic [1:0]    FlagW;
    logic          valid, stall, PCS, RegW, MemW, cnt_clr;
    logic          PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0]    Flags;
    logic [CW-1:0] squash_cnt;
`ifdef COND_NV_TRAP_EN
    logic          trap;
`endif

    cond_unit #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ALUFlags   (ALUFlags),
        .Cond       (Cond),
        .FlagW      (FlagW),
        .valid      (valid),
        .stall      (stall),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .cnt_clr    (cnt_clr),
        .PCSrc      (PCSrc),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .CondEx     (CondEx),
        .Flags      (Flags),
        .squash_cnt (squash_cnt)
`ifdef COND_NV_TRAP_EN
        ,
        .trap       (trap)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: flags as separate booleans, counter as a plain int
    bit mn, mz, mc, mv;
    int mcnt;
    bit mtrap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Condition codes come in true/inverted pairs; AL always, NV per build
    function automatic bit mcond(input int c);
        bit r;
        case (c / 2)
            0: r = mz;
            1: r = mc;
            2: r = mn;
            3: r = mv;
            4: r = mc && !mz;
            5: r = (mn == mv);
            6: r = !mz && (mn == mv);
            default: r = 1'b1;
        endcase
        if (c < 14 && (c % 2) == 1) r = !r;
`ifdef COND_NV_TRAP_EN
        if (c == 15) r = 1'b0;
`endif
        return r;
    endfunction

    function automatic logic [3:0] mflags();
        return {mv, mn, mz, mc};
    endfunction

    task automatic set_in(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] alu,
                          input logic vl, input logic st, input logic p, input logic r,
                          input logic m, input logic clr);
        Cond = c; FlagW = fw; ALUFlags = alu; valid = vl; stall = st;
        PCS = p; RegW = r; MemW = m; cnt_clr = clr;
    endtask

    // One clock: check combinational outputs mid-cycle, advance model, check state
    task automatic cycle();
        bit cex, fire;
        @(negedge clk);
        cex  = mcond(int'(Cond));
        fire = valid && !stall;
        chk("condex",   CondEx,   cex);
        chk("pcsrc",    PCSrc,    PCS  && cex && fire);
        chk("regwrite", RegWrite, RegW && cex && fire);
        chk("memwrite", MemWrite, MemW && cex && fire);
        @(posedge clk);
        if (fire && cex) begin
            if (FlagW[1]) begin mn = ALUFlags[2]; mz = ALUFlags[1]; end
            if (FlagW[0]) begin mc = ALUFlags[0]; mv = ALUFlags[3]; end
        end
        if (!stall) begin
            if (cnt_clr) mcnt = 0;
            else if (valid && !cex && mcnt < CMAX) mcnt++;
        end
        mtrap = fire && (Cond == 4'b1111);
        #1;
        chk("flags", Flags, mflags());
        chk("squash_cnt", squash_cnt, mcnt);
`ifdef COND_NV_TRAP_EN
        chk("trap", trap, mtrap);
`endif
    endtask

    task automatic model_reset();
        mn = 0; mz = 0; mc = 0; mv = 0; mcnt = 0; mtrap = 0;
    endtask

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Decode table: {stored flags {V,N,Z,C}, Cond, expected CondEx}
        tbl.push_back('{4'b0000, 4'b0000, 1'b0});
        tbl.push_back('{4'b0000, 4'b0001, 1'b1});
        tbl.push_back('{4'b0010, 4'b0000, 1'b1});
        tbl.push_back('{4'b0001, 4'b0010, 1'b1});
        tbl.push_back('{4'b0001, 4'b0011, 1'b0});
        tbl.push_back('{4'b0100, 4'b0101, 1'b0});
        tbl.push_back('{4'b1000, 4'b0110, 1'b1});
        tbl.push_back('{4'b1000, 4'b0111, 1'b0});
        tbl.push_back('{4'b0001, 4'b1000, 1'b1});
        tbl.push_back('{4'b0011, 4'b1000, 1'b0});
        tbl.push_back('{4'b0011, 4'b1001, 1'b1});
        tbl.push_back('{4'b0100, 4'b1011, 1'b1});
        tbl.push_back('{4'b0100, 4'b1010, 1'b0});
        tbl.push_back('{4'b1100, 4'b1010, 1'b1});
        tbl.push_back('{4'b0000, 4'b1100, 1'b1});
        tbl.push_back('{4'b0010, 4'b1100, 1'b0});
        tbl.push_back('{4'b0010, 4'b1101, 1'b1});
        tbl.push_back('{4'b1000, 4'b1101, 1'b1});
        tbl.push_back('{4'b1111, 4'b1110, 1'b1});
`ifdef COND_NV_TRAP_EN
        tbl.push_back('{4'b1111, 4'b1111, 1'b0});
`else
        tbl.push_back('{4'b1111, 4'b1111, 1'b1});
`endif

        // Reset state
        reset_n = 1'b0;
        set_in(4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        chk("rst_flags", Flags, 4'b0000);
        chk("rst_cnt", squash_cnt, 0);
        #10 reset_n = 1'b1;

        // EQ after reset fails, RegWrite suppressed, one squash counted
        @(posedge clk); #1;
        set_in(4'b0000, 2'b00, 4'b0000, 1, 0, 0, 1, 0, 0);
        #1;
        chk("eq_after_rst_condex", CondEx, 1'b0);
        chk("eq_after_rst_regwrite", RegWrite, 1'b0);
        cycle();
        chk("eq_after_rst_cnt", squash_cnt, 1);
        set_in(4'b0001, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0);
        #1;
        chk("ne_after_rst_condex", CondEx, 1'b1);

        // Decode table
        foreach (tbl[i]) begin
            set_in(4'b1110, 2'b11, tbl[i].flags, 1, 0, 0, 0, 0, 0);
            cycle();
            set_in(tbl[i].cond, 2'b00, 4'b0000, 0, 0, 0, 0, 0, 0);
            #1;
            chk("table_condex", CondEx, tbl[i].exp);
        end

        // Flag write becomes visible exactly one cycle later
        set_in(4'b1110, 2'b11, 4'b0000, 1, 0, 0, 0, 0, 0);
        cycle();
        set_in(4'b1110, 2'b11, 4'b0010, 1, 0, 0, 0, 0, 0);
        cycle();
        chk("z_load_flags", Flags, 4'b0010);
        set_in(4'b0000, 2'b00, 4'b0000, 1, 0, 0, 1, 0, 0);
        #1;
        chk("z_next_regwrite", RegWrite, 1'b1);
        cycle();
        set_in(4'b0000, 2'b00, 4'b0000, 0, 0, 0, 1, 0, 0);
        #1;
        chk("z_after_regwrite", RegWrite, 1'b0);
        cycle();

        // N=1,V=0: LT executes; GE squashed and must not write flags
        set_in(4'b1110, 2'b11, 4'b0100, 1, 0, 0, 0, 0, 0);
        cycle();
        set_in(4'b1011, 2'b00, 4'b0000, 1, 0, 0, 0, 1, 0);
        #1;
        chk("lt_memwrite", MemWrite, 1'b1);
        cycle();
        set_in(4'b1010, 2'b11, 4'b1111, 1, 0, 0, 0, 1, 0);
        #1;
        chk("ge_memwrite", MemWrite, 1'b0);
        cycle();
        chk("ge_flags_hold", Flags, 4'b0100);

        // Partial update: only N,Z load
        set_in(4'b1110, 2'b11, 4'b0000, 1, 0, 0, 0, 0, 0);
        cycle();
        set_in(4'b1110, 2'b10, 4'b1111, 1, 0, 0, 0, 0, 0);
        cycle();
        chk("nz_only_flags", Flags, 4'b0110);

        // Saturation: clear, reach all-ones minus 1, then three more failures
        set_in(4'b1110, 2'b11, 4'b0000, 1, 0, 0, 0, 0, 1);
        cycle();
        chk("cnt_clear", squash_cnt, 0);
        for (int i = 0; i < CMAX - 1; i++) begin
            set_in(4'b0000, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 0);
            cycle();
        end
        chk("cnt_max_minus1", squash_cnt, CMAX - 1);
        for (int i = 0; i < 3; i++) begin
            set_in(4'b0000, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 0);
            cycle();
            chk("cnt_saturate", squash_cnt, CMAX);
        end
        set_in(4'b0000, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 1);
        cycle();
        chk("cnt_clr_priority", squash_cnt, 0);

        // Stall: outputs zero and flags hold
        set_in(4'b1110, 2'b11, 4'b0101, 1, 0, 0, 0, 0, 0);
        cycle();
        set_in(4'b1110, 2'b11, 4'b1010, 1, 1, 1, 1, 1, 0);
        #1;
        chk("stall_pcsrc", PCSrc, 1'b0);
        chk("stall_regwrite", RegWrite, 1'b0);
        chk("stall_memwrite", MemWrite, 1'b0);
        cycle();
        chk("stall_flags_hold", Flags, 4'b0101);

        // Mid-cycle reset with a flag write pending
        set_in(4'b0000, 2'b00, 4'b0000, 1, 0, 0, 0, 0, 0);
        cycle();
        set_in(4'b1110, 2'b11, 4'b1111, 1, 0, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_flags", Flags, 4'b0000);
        chk("async_rst_cnt", squash_cnt, 0);
        @(posedge clk); #1;
        chk("rst_discard_write", Flags, 4'b0000);
        #2 reset_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_in(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                   4'($urandom_range(0, 15)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
